// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue unit: default sizes, FSM state encoding
// and the op-code values carried on instr_op / alu_op.
package alu_issue_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int REG_CNT_DEF = 4;
   localparam int IDX_W       = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_AND = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: two combinational read ports, one write port, async reset.
// With ALU_ISSUE_DBG_EN defined a third combinational read port is added.
module alu_issue_regfile
   import alu_issue_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_CNT = REG_CNT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr_a,
   input  logic [IDX_W-1:0]  raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
`ifdef ALU_ISSUE_DBG_EN
   ,
   input  logic [IDX_W-1:0]  raddr_d,
   output logic [DATA_W-1:0] rdata_d
`endif
);

   logic [DATA_W-1:0] mem_q [REG_CNT];
   logic [DATA_W-1:0] mem_d [REG_CNT];

   // next contents: the addressed entry takes wdata on a write
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[waddr] = wdata;
      end else begin
         mem_d = mem_q;
      end
   end

   // storage, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_a = mem_q[raddr_a];
   assign rdata_b = mem_q[raddr_b];
`ifdef ALU_ISSUE_DBG_EN
   assign rdata_d = mem_q[raddr_d];
`endif

endmodule

// File: rtl/alu_issue_unit.sv
// Single-issue front end for an external combinational ALU: IDLE/EXEC/DONE FSM,
// operand fetch, writeback and Z flag. ALU_ISSUE_DBG_EN adds a register peek port.
module alu_issue_unit
   import alu_issue_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int REG_CNT = REG_CNT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [1:0]        instr_op,
   input  logic [IDX_W-1:0]  instr_rd,
   input  logic [IDX_W-1:0]  instr_rs1,
   input  logic [IDX_W-1:0]  instr_rs2,
   input  logic              instr_imm_sel,
   input  logic [DATA_W-1:0] instr_imm,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [1:0]        alu_op,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   output logic              done,
   output logic [IDX_W-1:0]  wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              zero_flag
`ifdef ALU_ISSUE_DBG_EN
   ,
   input  logic [IDX_W-1:0]  dbg_addr,
   output logic [DATA_W-1:0] dbg_data
`endif
);

   state_e             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [IDX_W-1:0]   rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
   logic               imm_sel_q, imm_sel_d;
   logic [DATA_W-1:0]  imm_q, imm_d;
   logic [IDX_W-1:0]   wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0]  wb_data_q, wb_data_d;
   logic               zero_q, zero_d;
   logic               accept_s;
   logic               exec_s;
   logic [DATA_W-1:0]  rdata_a_s, rdata_b_s;

   assign accept_s = instr_valid & instr_ready;
   assign exec_s   = (state_q == ST_EXEC);

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state: EXEC always lasts one cycle, DONE doubles as an accept slot
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: state_d = accept_s ? ST_EXEC : ST_IDLE;
         ST_EXEC: state_d = ST_DONE;
         ST_DONE: state_d = accept_s ? ST_EXEC : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // outputs: ready also held low while rst is asserted
   always_comb begin
      instr_ready = 1'b0;
      done        = 1'b0;
      alu_a       = '0;
      alu_b       = '0;
      alu_op      = 2'b00;
      case (state_q)
         ST_IDLE: instr_ready = ~rst;
         ST_EXEC: begin
            alu_a  = rdata_a_s;
            alu_b  = imm_sel_q ? imm_q : rdata_b_s;
            alu_op = op_q;
         end
         ST_DONE: begin
            instr_ready = ~rst;
            done        = 1'b1;
         end
         default: instr_ready = 1'b0;
      endcase
   end

   // instruction latch and writeback report next values
   always_comb begin
      op_d      = op_q;
      rd_d      = rd_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      imm_sel_d = imm_sel_q;
      imm_d     = imm_q;
      wb_rd_d   = wb_rd_q;
      wb_data_d = wb_data_q;
      zero_d    = zero_q;
      if (accept_s) begin
         op_d      = instr_op;
         rd_d      = instr_rd;
         rs1_d     = instr_rs1;
         rs2_d     = instr_rs2;
         imm_sel_d = instr_imm_sel;
         imm_d     = instr_imm;
      end else if (exec_s) begin
         wb_rd_d   = rd_q;
         wb_data_d = alu_result;
         zero_d    = alu_zero;
      end else begin
         op_d      = op_q;
      end
   end

   // datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q      <= 2'b00;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_sel_q <= 1'b0;
         imm_q     <= '0;
         wb_rd_q   <= '0;
         wb_data_q <= '0;
         zero_q    <= 1'b0;
      end else begin
         op_q      <= op_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         imm_sel_q <= imm_sel_d;
         imm_q     <= imm_d;
         wb_rd_q   <= wb_rd_d;
         wb_data_q <= wb_data_d;
         zero_q    <= zero_d;
      end
   end

   assign wb_rd     = wb_rd_q;
   assign wb_data   = wb_data_q;
   assign zero_flag = zero_q;

   alu_issue_regfile #(
      .DATA_W  (DATA_W),
      .REG_CNT (REG_CNT)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .we      (exec_s),
      .waddr   (rd_q),
      .wdata   (alu_result),
      .raddr_a (rs1_q),
      .raddr_b (rs2_q),
      .rdata_a (rdata_a_s),
      .rdata_b (rdata_b_s)
`ifdef ALU_ISSUE_DBG_EN
      ,
      .raddr_d (dbg_addr),
      .rdata_d (dbg_data)
`endif
   );

endmodule

// File: tb/tb_alu_issue_unit.sv
// Randomized scoreboard bench for alu_issue_unit with a register-array reference
// model and an ALU stand-in; directed sequences exercise the documented scenarios.
module tb_alu_issue_unit;
   import alu_issue_pkg::*;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [1:0]    instr_op = 2'b00;
   logic [1:0]    instr_rd = 2'b00, instr_rs1 = 2'b00, instr_rs2 = 2'b00;
   logic          instr_imm_sel = 1'b0;
   logic [DW-1:0] instr_imm = 8'h00;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic [1:0]    alu_op;
   logic          alu_zero;
   logic          done;
   logic [1:0]    wb_rd;
   logic [DW-1:0] wb_data;
   logic          zero_flag;
`ifdef ALU_ISSUE_DBG_EN
   logic [1:0]    dbg_addr = 2'b00;
   logic [DW-1:0] dbg_data;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_issue_unit #(.DATA_W(DW), .REG_CNT(4)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .instr_imm_sel(instr_imm_sel), .instr_imm(instr_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .done(done), .wb_rd(wb_rd), .wb_data(wb_data), .zero_flag(zero_flag)
`ifdef ALU_ISSUE_DBG_EN
      , .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`endif
   );

   function automatic logic [DW-1:0] ref_alu(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // downstream ALU stand-in
   assign alu_result = ref_alu(alu_op, alu_a, alu_b);
   assign alu_zero   = (alu_result == 8'h00);

   typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic [1:0] op; } ex_t;
   typedef struct { logic [1:0] rd; logic [DW-1:0] data; logic z; } wb_t;

   ex_t           exq[$];
   wb_t           wbq[$];
   logic [DW-1:0] m [4];
   logic          exp_exec, exp_done;

   function automatic ex_t mk_ex(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [1:0] op);
      ex_t e;
      e.a = a; e.b = b; e.op = op;
      return e;
   endfunction

   function automatic wb_t mk_wb(input logic [1:0] rd, input logic [DW-1:0] d);
      wb_t w;
      w.rd = rd; w.data = d; w.z = (d == 8'h00);
      return w;
   endfunction

   // reference model: an instruction is taken whenever offered outside its EXEC cycle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_exec <= 1'b0;
         exp_done <= 1'b0;
         for (int i = 0; i < 4; i++) m[i] <= 8'h00;
         exq.delete();
         wbq.delete();
      end else begin
         exp_done <= exp_exec;
         exp_exec <= instr_valid && !exp_exec;
         if (instr_valid && !exp_exec) begin
            exq.push_back(mk_ex(m[instr_rs1], instr_imm_sel ? instr_imm : m[instr_rs2], instr_op));
            wbq.push_back(mk_wb(instr_rd, ref_alu(instr_op, m[instr_rs1], instr_imm_sel ? instr_imm : m[instr_rs2])));
            m[instr_rd] <= ref_alu(instr_op, m[instr_rs1], instr_imm_sel ? instr_imm : m[instr_rs2]);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor: compares DUT outputs against the model on every falling edge
   initial begin : monitor
      ex_t e;
      wb_t w;
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst_ready", {31'd0, instr_ready}, 32'd0);
            chk("rst_done", {31'd0, done}, 32'd0);
            chk("rst_wb", {15'd0, zero_flag, 6'd0, wb_rd, wb_data}, 32'd0);
         end else begin
            chk("ready", {31'd0, instr_ready}, {31'd0, !exp_exec});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            if (exp_exec) begin
               if (exq.size() == 0) begin
                  chk("exec_queue_empty", 32'd1, 32'd0);
               end else begin
                  e = exq.pop_front();
                  chk("alu_a", {24'd0, alu_a}, {24'd0, e.a});
                  chk("alu_b", {24'd0, alu_b}, {24'd0, e.b});
                  chk("alu_op", {30'd0, alu_op}, {30'd0, e.op});
               end
            end else begin
               chk("alu_idle", {14'd0, alu_op, alu_a, alu_b}, 32'd0);
            end
            if (done) begin
               if (wbq.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  w = wbq.pop_front();
                  chk("wb_rd", {30'd0, wb_rd}, {30'd0, w.rd});
                  chk("wb_data", {24'd0, wb_data}, {24'd0, w.data});
                  chk("zero_flag", {31'd0, zero_flag}, {31'd0, w.z});
               end
            end
`ifdef ALU_ISSUE_DBG_EN
            if (!exp_exec) chk("dbg_data", {24'd0, dbg_data}, {24'd0, m[dbg_addr]});
`endif
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input logic isel, input logic [DW-1:0] imm);
      logic ok;
      instr_op = op; instr_rd = rd; instr_rs1 = rs1; instr_rs2 = rs2;
      instr_imm_sel = isel; instr_imm = imm; instr_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ok = !exp_exec && !rst;
         @(posedge clk);
         #1;
         if (ok) return;
      end
      chk("issue_timeout", 32'd1, 32'd0);
   endtask

   task automatic idle(input int n);
      instr_valid = 1'b0;
      instr_op = 2'($urandom_range(3)); instr_rd = 2'($urandom_range(3));
      instr_rs1 = 2'($urandom_range(3)); instr_rs2 = 2'($urandom_range(3));
      instr_imm_sel = 1'($urandom_range(1)); instr_imm = 8'($urandom_range(255));
      repeat (n) @(posedge clk);
      #1;
   endtask

   // directed check of the writeback report against literal values
   task automatic expect_wb(input string name, input logic [1:0] rd, input logic [DW-1:0] data, input logic z);
      bit seen = 1'b0;
      instr_valid = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         chk({name, "_timeout"}, 32'd1, 32'd0);
      end else begin
         chk({name, "_rd"}, {30'd0, wb_rd}, {30'd0, rd});
         chk({name, "_data"}, {24'd0, wb_data}, {24'd0, data});
         chk({name, "_z"}, {31'd0, zero_flag}, {31'd0, z});
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      // first offer lands on the first edge after release
      issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05);
      expect_wb("add_imm", 2'd1, 8'h05, 1'b0);
      issue(OP_SUB, 2'd2, 2'd1, 2'd0, 1'b1, 8'h05);
      expect_wb("sub_zero", 2'd2, 8'h00, 1'b1);
      issue(OP_SUB, 2'd3, 2'd0, 2'd1, 1'b0, 8'h00);
      expect_wb("sub_wrap", 2'd3, 8'hFB, 1'b0);
      // back-to-back with valid held high; second reads the first's result
      issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h03);
      issue(OP_ADD, 2'd1, 2'd1, 2'd1, 1'b0, 8'h00);
      expect_wb("b2b", 2'd1, 8'h06, 1'b0);
      issue(OP_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F);
      issue(OP_OR, 2'd2, 2'd0, 2'd0, 1'b1, 8'hF0);
      issue(OP_AND, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
      expect_wb("and", 2'd3, 8'h00, 1'b1);
      issue(OP_OR, 2'd3, 2'd1, 2'd2, 1'b0, 8'h00);
      expect_wb("or", 2'd3, 8'hFF, 1'b0);
`ifdef ALU_ISSUE_DBG_EN
      issue(OP_OR, 2'd2, 2'd0, 2'd0, 1'b1, 8'hAA);
      instr_valid = 1'b0;
      dbg_addr = 2'd2;
      @(posedge clk);
      #1 chk("dbg_after_write", {24'd0, dbg_data}, 32'h0000_00AA);
      idle(1);
`endif
      // reset in the middle of EXEC aborts the instruction
      issue(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h07);
      instr_valid = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      issue(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00);
      expect_wb("after_abort", 2'd2, 8'h00, 1'b1);
      // random traffic, gaps of zero to two cycles
      repeat (200) begin
`ifdef ALU_ISSUE_DBG_EN
         dbg_addr = 2'($urandom_range(3));
`endif
         issue(2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)),
               2'($urandom_range(3)), 1'($urandom_range(1)),
               ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom_range(255)));
         idle($urandom_range(2));
      end
      idle(4);
      chk("drain", exq.size() + wbq.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
